// File: rtl/traffic_ctrl_fsm.sv
// traffic_ctrl_fsm: North/East light sequencer with registered light/load outputs; `TRAFFIC_ALLRED_EN adds AR1/AR2 clearance
module traffic_ctrl_fsm #(
    parameter int G_MIN   = 8,
    parameter int Y_TIME  = 3,
    parameter int AR_TIME = 2,
    parameter int TW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       not_r,
    input  logic       en_s,
    input  logic       c_and_l,
    input  logic       l_or_notc,
    output logic       s_NR,
    output logic       en_NR,
    output logic       s_NG,
    output logic       en_NG,
    output logic       s_NY,
    output logic       en_NY,
    output logic       s_ER,
    output logic       en_ER,
    output logic       s_EG,
    output logic       en_EG,
    output logic       s_EY,
    output logic       en_EY,
    output logic [1:0] s_IC,
    output logic       en_IC,
    output logic [2:0] state
);
    typedef enum logic [2:0] {IDLE = 3'd0, NG = 3'd1, NY = 3'd2, AR1 = 3'd3, EG = 3'd4, EY = 3'd5, AR2 = 3'd6} state_t;
`ifdef TRAFFIC_ALLRED_EN
    localparam state_t AFTER_NY = AR1;
    localparam state_t AFTER_EY = AR2;
`else
    localparam state_t AFTER_NY = EG;
    localparam state_t AFTER_EY = NG;
`endif
    state_t        cur, nxt;
    logic [TW-1:0] timer, dur;
    logic [5:0]    lt;
    logic [1:0]    ic;
    logic          done, chg, grn;
    assign state = cur;
    assign done  = timer == '0;
    // next state: run permit loss overrides every other transition
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    nxt = en_s ? NG : IDLE;
            NG:      nxt = (done && c_and_l) ? NY : NG;
            NY:      nxt = done ? AFTER_NY : NY;
            AR1:     nxt = done ? EG : AR1;
            EG:      nxt = (done && l_or_notc) ? EY : EG;
            EY:      nxt = done ? AFTER_EY : EY;
            AR2:     nxt = done ? NG : AR2;
            default: nxt = IDLE;
        endcase
        if (!not_r) nxt = IDLE;
    end
    // decode of the state being entered: phase length, lights and counter-input select
    always_comb begin
        chg = nxt != cur;
        grn = nxt == NG || nxt == EG;
        dur = grn ? TW'(G_MIN - 1) :
              (nxt == NY || nxt == EY) ? TW'(Y_TIME - 1) :
              (nxt == AR1 || nxt == AR2) ? TW'(AR_TIME - 1) : '0;
        lt  = {nxt != NG && nxt != NY, nxt == NG, nxt == NY,
               nxt != EG && nxt != EY, nxt == EG, nxt == EY};
        ic  = nxt == IDLE ? 2'b00 : nxt == NG ? 2'b10 : nxt == EG ? 2'b11 : 2'b01;
    end
    // state, phase timer and registered outputs; reset loads all-red every clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur   <= IDLE;
            timer <= '0;
            {s_NR, s_NG, s_NY, s_ER, s_EG, s_EY} <= 6'b100100;
            {en_NR, en_NG, en_NY, en_ER, en_EG, en_EY} <= 6'b111111;
            s_IC  <= 2'b00;
            en_IC <= 1'b1;
        end else begin
            cur   <= nxt;
            timer <= chg ? dur : done ? timer : timer - TW'(1);
            {s_NR, s_NG, s_NY, s_ER, s_EG, s_EY} <= lt;
            {en_NR, en_NG, en_NY, en_ER, en_EG, en_EY} <= {6{chg}};
            s_IC  <= ic;
            en_IC <= chg || grn;
        end
    end
endmodule

// File: tb/tb_traffic_ctrl_fsm.sv
// tb_traffic_ctrl_fsm: directed sequence through every phase, the hold/abort cases and reset
module tb_traffic_ctrl_fsm;
    logic clk = 1'b0, rst = 1'b1, not_r = 1'b1, en_s = 1'b0, c_and_l = 1'b0, l_or_notc = 1'b0;
    logic s_NR, en_NR, s_NG, en_NG, s_NY, en_NY, s_ER, en_ER, s_EG, en_EG, s_EY, en_EY, en_IC;
    logic [1:0] s_IC;
    logic [2:0] state;
    logic [5:0] env, lts;
    int total = 0, bad = 0;

    traffic_ctrl_fsm dut (
        .clk(clk), .rst(rst), .not_r(not_r), .en_s(en_s), .c_and_l(c_and_l), .l_or_notc(l_or_notc),
        .s_NR(s_NR), .en_NR(en_NR), .s_NG(s_NG), .en_NG(en_NG), .s_NY(s_NY), .en_NY(en_NY),
        .s_ER(s_ER), .en_ER(en_ER), .s_EG(s_EG), .en_EG(en_EG), .s_EY(s_EY), .en_EY(en_EY),
        .s_IC(s_IC), .en_IC(en_IC), .state(state)
    );

    always #5 clk = ~clk;
    assign env = {en_NR, en_NG, en_NY, en_ER, en_EG, en_EY};
    assign lts = {s_NR, s_NG, s_NY, s_ER, s_EG, s_EY};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] lights(input logic [2:0] st);
        case (st)
            3'd1:    return 6'b010100;
            3'd2:    return 6'b001100;
            3'd4:    return 6'b100010;
            3'd5:    return 6'b100001;
            default: return 6'b100100;
        endcase
    endfunction

    task automatic entry_chk(input logic [2:0] st, input logic [1:0] ic);
        chk($sformatf("state@%0d", st), state, st);
        chk($sformatf("en_pulse@%0d", st), env, 6'h3f);
        chk($sformatf("en_IC_pulse@%0d", st), en_IC, 1'b1);
        chk($sformatf("s_IC@%0d", st), s_IC, ic);
        chk($sformatf("lights@%0d", st), lts, lights(st));
    endtask

    // entered st one cycle ago; optionally raise a condition input at cycle 'at'; measure stay length
    task automatic phase(input logic [2:0] st, input int len, input logic [1:0] ic, input int at, input int which);
        int n = 0;
        entry_chk(st, ic);
        while (n < 200) begin
            if (n == at) begin
                if (which == 1) c_and_l = 1'b1;
                else l_or_notc = 1'b1;
            end
            @(negedge clk);
            n++;
            if (state != st) break;
            if (n == 1) begin
                chk($sformatf("en_off@%0d", st), env, 6'h00);
                chk($sformatf("en_IC_hold@%0d", st), en_IC, (st == 3'd1 || st == 3'd4));
            end
        end
        chk($sformatf("len@%0d", st), n, len);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", state, 3'd0);
        chk("rst_en", env, 6'h3f);
        chk("rst_en_IC", en_IC, 1'b1);
        chk("rst_lights", lts, 6'b100100);
        chk("rst_s_IC", s_IC, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_state", state, 3'd0);
        chk("idle_en", env, 6'h00);
        chk("idle_en_IC", en_IC, 1'b0);
        chk("idle_lights", lts, 6'b100100);
        en_s = 1'b1;
        @(negedge clk);
        en_s = 1'b0;
        c_and_l = 1'b1;
        phase(3'd1, 8, 2'b10, -1, 0);
        phase(3'd2, 3, 2'b01, -1, 0);
`ifdef TRAFFIC_ALLRED_EN
        phase(3'd3, 2, 2'b01, -1, 0);
`endif
        phase(3'd4, 8, 2'b11, 3, 2);
        c_and_l = 1'b0;
        l_or_notc = 1'b0;
        phase(3'd5, 3, 2'b01, -1, 0);
`ifdef TRAFFIC_ALLRED_EN
        phase(3'd6, 2, 2'b01, -1, 0);
`endif
        phase(3'd1, 21, 2'b10, 20, 1);
        phase(3'd2, 3, 2'b01, -1, 0);
`ifdef TRAFFIC_ALLRED_EN
        phase(3'd3, 2, 2'b01, -1, 0);
`endif
        l_or_notc = 1'b1;
        phase(3'd4, 8, 2'b11, -1, 0);
        entry_chk(3'd5, 2'b01);
        @(negedge clk);
        not_r = 1'b0;
        @(negedge clk);
        entry_chk(3'd0, 2'b00);
        en_s = 1'b1;
        @(negedge clk);
        chk("hold_idle_state", state, 3'd0);
        chk("hold_idle_en", env, 6'h00);
        @(negedge clk);
        chk("hold_idle_state2", state, 3'd0);
        not_r = 1'b1;
        @(negedge clk);
        en_s = 1'b0;
        entry_chk(3'd1, 2'b10);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", state, 3'd0);
        chk("arst_en", env, 6'h3f);
        chk("arst_lights", lts, 6'b100100);
        chk("arst_s_IC", s_IC, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_state", state, 3'd0);
        chk("post_en", env, 6'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
